multiplicador_sequencial: RTL and testbench

MULTIPLICADOR_SEQUENCIAL -- requirements
Module: multiplicador_sequencial

---
 rtl/multiplicador_pkg.sv | 15 +
 rtl/contador_iter.sv | 26 ++
 rtl/multiplicador_sequencial.sv | 110 +++++++++++
 tb/tb_multiplicador_sequencial.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so the counter can reach (and pass) WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/contador_iter.sv
// Iteration up-counter with synchronous clear, enable and terminal-count flag.
module contador_iter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + CNT_W'(1);
  end

  assign tc = (count == limit);

endmodule

// File: rtl/multiplicador_sequencial.sv
// Sequential shift-add multiplier, unsigned or two's-complement, one bit per cycle.
//   state | meaning
//   IDLE  | waiting for Start; operands captured on Start
//   RUN   | WIDTH shift-add iterations, then one cycle to load Produto
//   DONE  | Finalizado pulse, back to IDLE on the next edge
module multiplicador_sequencial
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Finalizado,
  output logic [2*WIDTH-1:0] Produto
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  logic cnt_clear, cnt_en, cnt_tc;

  contador_iter #(.CNT_W(CNT_W)) u_contador (
    .clk    (Clk),
    .rst_n  (Rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .limit  (ITERS),
    .tc     (cnt_tc)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
          cnt_clear  = 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (cnt_tc)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy       = (state != IDLE);
  assign Finalizado = (state == DONE);

  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
  assign mag_a = (Signed && A[WIDTH-1]) ? -A : A;
  assign mag_b = (Signed && B[WIDTH-1]) ? -B : B;

  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_step = {sum, acc[WIDTH-1:1]};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mcand   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      Produto <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand <= mag_a;
            acc   <= {{WIDTH{1'b0}}, mag_b};
            neg   <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          end
        end
        RUN: begin
          if (!cnt_tc)
            acc <= acc_step;
          else
            Produto <= neg ? -acc : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed-vector bench for multiplicador_sequencial at WIDTH 8, 16 and 2.
module tb_multiplicador_sequencial;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 0, sgn8 = 0, busy8, fin8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] prod8;

  logic        start16 = 0, sgn16 = 0, busy16, fin16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] prod16;

  logic        start2 = 0, sgn2 = 0, busy2, fin2;
  logic [1:0]  a2 = 0, b2 = 0;
  logic [3:0]  prod2;

  int tests = 0;
  int failed = 0;

  multiplicador_sequencial #(.WIDTH(8)) dut8 (
    .Clk(clk), .Rst(rst), .Start(start8), .Signed(sgn8), .A(a8), .B(b8),
    .Busy(busy8), .Finalizado(fin8), .Produto(prod8));

  multiplicador_sequencial #(.WIDTH(16)) dut16 (
    .Clk(clk), .Rst(rst), .Start(start16), .Signed(sgn16), .A(a16), .B(b16),
    .Busy(busy16), .Finalizado(fin16), .Produto(prod16));

  multiplicador_sequencial #(.WIDTH(2)) dut2 (
    .Clk(clk), .Rst(rst), .Start(start2), .Signed(sgn2), .A(a2), .B(b2),
    .Busy(busy2), .Finalizado(fin2), .Produto(prod2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the edge that leaves DONE.
  // inject >= 0 pulses Start with other operands after RUN edge 'inject'.
  task automatic op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string name, input int inject);
    int busy_drops = 0;
    sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; sgn8 = ~sgn;
    check({name, "_busy0"}, busy8, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      start8 = (k == inject);
      if (k == inject) begin a8 = 8'h09; b8 = 8'h09; end
      if (k <= 9 && !busy8) busy_drops++;
      if (k == 8) check({name, "_fin_early"}, fin8, 1'b0);
      if (k == 9) begin
        check({name, "_fin"}, fin8, 1'b1);
        check({name, "_prod"}, prod8, exp);
      end
      if (k == 10) begin
        check({name, "_fin_one"}, fin8, 1'b0);
        check({name, "_idle"}, busy8, 1'b0);
        check({name, "_hold"}, prod8, exp);
      end
    end
    check({name, "_busy_drops"}, busy_drops, 0);
  endtask

  task automatic op16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    logic [31:0] exp;
    int cyc = 0;
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    exp = sgn ? 32'(sa * sb) : ({16'b0, a} * {16'b0, b});
    sgn16 = sgn; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; a16 = ~a; b16 = ~b;
    while (!fin16 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (!fin16) check("w16_timeout", 0, 1);
    else check($sformatf("w16_%0d_%h_%h", sgn, a, b), prod16, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op2(input logic sgn, input logic [1:0] a, input logic [1:0] b,
                     input logic [3:0] exp, input string name);
    sgn2 = sgn; a2 = a; b2 = b; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) begin
        check({name, "_fin"}, fin2, 1'b1);
        check({name, "_prod"}, prod2, exp);
      end
    end
  endtask

  vec_t vecs[9];

  initial begin
    int fin_seen;
    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff"};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, "s_80_80"};
    vecs[2] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81, "s_ff_7f"};
    vecs[3] = '{1'b0, 8'h00, 8'hAB, 16'h0000, "u_00_ab"};
    vecs[4] = '{1'b0, 8'h03, 8'h05, 16'h000F, "u_03_05"};
    vecs[5] = '{1'b1, 8'h80, 8'h7F, 16'hC080, "s_80_7f"};
    vecs[6] = '{1'b1, 8'h05, 8'hFD, 16'hFFF1, "s_05_fd"};
    vecs[7] = '{1'b0, 8'h80, 8'h7F, 16'h3F80, "u_80_7f"};
    vecs[8] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, "s_7f_7f"};

    #1;
    check("rst_busy", busy8, 1'b0);
    check("rst_fin", fin8, 1'b0);
    check("rst_prod", prod8, 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Consecutive vectors start in the first IDLE cycle after DONE.
    for (int i = 0; i < 9; i++)
      op8(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, -1);

    op8(1'b0, 8'd6, 8'd7, 16'd42, "inject", 3);
    repeat (3) @(negedge clk);
    check("inject_no_queue", busy8, 1'b0);

    sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_fin", fin8, 1'b0);
    check("abort_prod", prod8, 16'h0);
    fin_seen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (fin8 || busy8) fin_seen++;
    end
    check("abort_no_fin", fin_seen, 0);
    op8(1'b0, 8'd200, 8'd100, 16'd20000, "after_rst", -1);

    op2(1'b1, 2'd2, 2'd2, 4'h4, "w2_s_2_2");
    op2(1'b0, 2'd3, 2'd3, 4'h9, "w2_u_3_3");
    op2(1'b1, 2'd3, 2'd1, 4'hF, "w2_s_m1_1");

    op16(1'b1, 16'h8000, 16'h8000);
    op16(1'b0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 1000; i++)
      op16(1'(i % 2), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
